aes_byte_loader: RTL and testbench

//   Upstream input stage for the Cipher core. Takes a byte-serial stream with a valid/ready

---
 rtl/aes_byte_loader.sv | 170 +++++++++++++++++
 tb/tb_aes_byte_loader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_byte_loader.sv
// ----------------------------------------------------------------------------
// aes_byte_loader
//   Input stage in front of the Cipher core. Collects a byte-serial stream
//   (valid/ready) into either an Nk-word key group or a 16-byte data block.
//   Byte 0 of each group selects the group type via key_load.
//   - Key groups are copied whole into key_out and flagged with key_valid.
//     They are never backpressured.
//   - Data blocks are copied whole into block_out and held with block_valid
//     until the Cipher side takes them with block_ready.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   flush        discard the partially filled group (ignored while holding)
//   key_load     group type, sampled on byte 0 only (1 = key, 0 = data)
//   in_byte      stream byte
//   in_valid     in_byte valid
//   in_ready     a byte can be taken this cycle
//   key_out      assembled key; the first byte is in the top 8 bits
//   key_valid    key_out holds a complete key
//   block_out    assembled data block; the first byte is in the top 8 bits
//   block_valid  block_out holds a complete block
//   block_ready  Cipher side accepts block_out
//
// Byte order: byte i of a group lands in bits [W-1-8i -: 8]. Read as a hex
// number, the stream therefore appears left to right in arrival order.
// ----------------------------------------------------------------------------
module aes_byte_loader #(
    parameter int Nk = 4,   // key length in 32-bit words (4, 6 or 8)
    parameter int NB = 16   // bytes per data block
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              key_load,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [32*Nk-1:0]  key_out,
    output logic              key_valid,
    output logic [8*NB-1:0]   block_out,
    output logic              block_valid,
    input  logic              block_ready
);

    localparam int KeyBytes = 4 * Nk;
    localparam int KeyW     = 32 * Nk;
    localparam int BlkW     = 8 * NB;
    localparam int MaxBytes = (KeyBytes > NB) ? KeyBytes : NB;
    localparam int IdxW     = $clog2(MaxBytes);

    localparam logic [IdxW-1:0] KeyLast = IdxW'(KeyBytes - 1);
    localparam logic [IdxW-1:0] BlkLast = IdxW'(NB - 1);

    typedef enum logic {
        FILL,   // taking bytes
        HOLD    // complete block waiting for the Cipher
    } loaderState;

    loaderState      state;
    logic [IdxW-1:0] idx;        // next byte position within the group
    logic            modeKey;    // type of the group in progress

    // Groups are built in shadows so the visible outputs only ever change
    // by a whole-group copy.
    logic [KeyW-1:0] keyShadow;
    logic [KeyW-1:0] keyNext;
    logic [BlkW-1:0] blockShadow;
    logic [BlkW-1:0] blockNext;

    logic accept;
    logic groupKey;
    logic groupLast;

    // Reset gates in_ready combinationally so no byte is ever consumed
    // during a reset cycle.
    assign in_ready = reset && (state == FILL);

    // A flush in the same cycle as a handshake wins: the byte is dropped.
    assign accept = in_valid && in_ready && !flush;

    // On byte 0 the group type comes straight from key_load; afterwards the
    // latched type is used and key_load is ignored.
    assign groupKey  = (idx == '0) ? key_load : modeKey;
    assign groupLast = groupKey ? (idx == KeyLast) : (idx == BlkLast);

    // Shadow contents with the incoming byte merged at idx. The final copy
    // to key_out/block_out uses these so the last byte appears in the same
    // edge that completes the group.
    always_comb begin
        keyNext   = keyShadow;
        blockNext = blockShadow;
        for (int i = 0; i < KeyBytes; i++) begin
            if (idx == IdxW'(i)) begin
                keyNext[KeyW-1-8*i -: 8] = in_byte;
            end
        end
        for (int i = 0; i < NB; i++) begin
            if (idx == IdxW'(i)) begin
                blockNext[BlkW-1-8*i -: 8] = in_byte;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= FILL;
            idx         <= '0;
            modeKey     <= 1'b0;
            keyShadow   <= '0;
            blockShadow <= '0;
            key_out     <= '0;
            key_valid   <= 1'b0;
            block_out   <= '0;
            block_valid <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (flush) begin
                        // Rewinding idx is enough to discard the partial
                        // group: every position is rewritten before the
                        // next copy-out.
                        idx <= '0;
                    end else if (accept) begin
                        if (idx == '0) begin
                            modeKey <= key_load;
                            // A new key invalidates the previous one from
                            // its first byte on; data groups leave it alone.
                            if (key_load) begin
                                key_valid <= 1'b0;
                            end
                        end

                        if (groupKey) begin
                            keyShadow <= keyNext;
                        end else begin
                            blockShadow <= blockNext;
                        end

                        if (groupLast) begin
                            idx <= '0;
                            if (groupKey) begin
                                // Keys are consumed by the key schedule
                                // without a handshake, so keep filling.
                                key_out   <= keyNext;
                                key_valid <= 1'b1;
                            end else begin
                                block_out   <= blockNext;
                                block_valid <= 1'b1;
                                state       <= HOLD;
                            end
                        end else begin
                            idx <= idx + IdxW'(1);
                        end
                    end
                end

                HOLD: begin
                    // in_ready is low here, so the earliest next byte is
                    // the cycle after this handshake.
                    if (block_ready) begin
                        block_valid <= 1'b0;
                        state       <= FILL;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_byte_loader.sv
// ----------------------------------------------------------------------------
// tb_aes_byte_loader
//   Two loaders (Nk=4 and Nk=8) share one stimulus bus; sel picks the active
//   one and the other is held in reset. The driver pushes every completed
//   group into an expected queue; a monitor pops on each rising
//   key_valid/block_valid and compares, and it also checks that a held
//   block stays stable.
// ----------------------------------------------------------------------------
module tb_aes_byte_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetN, sel, flush, keyLoad, inValid, blockReady;
    logic [7:0]  inByte;
    logic        rst4, rst8, rdy4, rdy8, kv4, kv8, bv4, bv8;
    logic [127:0] k4, b4, b8;
    logic [255:0] k8;

    logic         inReady, keyValid, blockValid;
    logic [255:0] keyOut;
    logic [127:0] blockOut;

    assign rst4       = resetN & ~sel;
    assign rst8       = resetN & sel;
    assign inReady    = sel ? rdy8 : rdy4;
    assign keyValid   = sel ? kv8 : kv4;
    assign blockValid = sel ? bv8 : bv4;
    assign keyOut     = sel ? k8 : {k4, 128'h0};
    assign blockOut   = sel ? b8 : b4;

    aes_byte_loader #(.Nk(4), .NB(16)) dut4 (
        .clk(clk), .reset(rst4), .flush(flush), .key_load(keyLoad),
        .in_byte(inByte), .in_valid(inValid), .in_ready(rdy4),
        .key_out(k4), .key_valid(kv4), .block_out(b4), .block_valid(bv4),
        .block_ready(blockReady)
    );

    aes_byte_loader #(.Nk(8), .NB(16)) dut8 (
        .clk(clk), .reset(rst8), .flush(flush), .key_load(keyLoad),
        .in_byte(inByte), .in_valid(inValid), .in_ready(rdy8),
        .key_out(k8), .key_valid(kv8), .block_out(b8), .block_valid(bv8),
        .block_ready(blockReady)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: bytes of the group in progress and the expected
    // results still waiting for the DUT to present them.
    logic [7:0]   cur[$];
    bit           curKey;
    logic [255:0] keyQ[$];
    logic [127:0] blkQ[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int keyLen();
        return sel ? 32 : 16;
    endfunction

    task automatic modelAccept(input logic [7:0] b, input logic kl);
        logic [255:0] e;
        if (cur.size() == 0) curKey = kl;
        cur.push_back(b);
        if (cur.size() == (curKey ? keyLen() : 16)) begin
            e = '0;
            foreach (cur[i]) e = (e << 8) | 256'(cur[i]);
            if (curKey) keyQ.push_back(e << (8 * (32 - cur.size())));
            else        blkQ.push_back(e[127:0]);
            cur.delete();
        end
    endtask

    // Called just after a negedge; returns just after the negedge that
    // follows the accepting posedge.
    task automatic sendByte(input logic [7:0] b, input logic kl, input bit rr);
        int n = 0;
        bit acc;
        inValid = 1'b1; inByte = b; keyLoad = kl;
        forever begin
            if (rr) blockReady = 1'($urandom_range(0, 1));
            #1 acc = inReady;
            @(negedge clk);
            if (acc) begin
                modelAccept(b, kl);
                break;
            end
            n++;
            if (n > 500) begin
                checks++; failures++;
                $display("FAIL accept_timeout got=stalled expected=accept byte=%h", b);
                break;
            end
        end
        inValid = 1'b0;
    endtask

    task automatic idle(input int n);
        inValid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic randomGroups(input int groups, input int gapMax);
        bit kl;
        int n;
        for (int g = 0; g < groups; g++) begin
            kl = 1'($urandom_range(0, 1));
            n  = kl ? keyLen() : 16;
            for (int i = 0; i < n; i++) begin
                idle($urandom_range(0, gapMax));
                sendByte(8'($urandom), (i == 0) ? kl : 1'($urandom_range(0, 1)), 1'b1);
                // Occasional mid-group flush with a byte offered alongside.
                if (i == 5 && $urandom_range(0, 4) == 0) begin
                    flush = 1'b1; inValid = 1'b1; inByte = 8'($urandom);
                    @(negedge clk);
                    flush = 1'b0; inValid = 1'b0;
                    cur.delete();
                    break;
                end
            end
        end
        blockReady = 1'b1;
        idle(4);
    endtask

    // Monitor
    bit           prevKv = 1'b0, prevBv = 1'b0;
    logic [127:0] heldBlk;
    logic [255:0] expK;
    logic [127:0] expB;
    always begin
        @(negedge clk);
        #2;
        if (keyValid && !prevKv) begin
            if (keyQ.size() == 0) begin
                checks++; failures++;
                $display("FAIL key_unexpected got=%h expected=none", keyOut);
            end else begin
                expK = keyQ.pop_front();
                check("key_out", keyOut, expK);
            end
        end
        if (blockValid && !prevBv) begin
            heldBlk = blockOut;
            if (blkQ.size() == 0) begin
                checks++; failures++;
                $display("FAIL block_unexpected got=%h expected=none", blockOut);
            end else begin
                expB = blkQ.pop_front();
                check("block_out", {128'h0, blockOut}, {128'h0, expB});
            end
        end else if (blockValid && prevBv && blockOut !== heldBlk) begin
            checks++; failures++;
            $display("FAIL block_unstable got=%h expected=%h", blockOut, heldBlk);
        end
        prevKv = keyValid;
        prevBv = blockValid;
    end

    initial begin
        resetN = 1'b0; sel = 1'b0; flush = 1'b0; keyLoad = 1'b1;
        inValid = 1'b1; inByte = 8'h5a; blockReady = 1'b0;

        // Reset held three cycles with a byte offered
        repeat (3) begin
            @(negedge clk);
            #1 check("reset_in_ready", 256'(inReady), 256'd0);
        end
        check("reset_key_valid", 256'(keyValid), 256'd0);
        check("reset_block_valid", 256'(blockValid), 256'd0);
        check("reset_key_out", keyOut, 256'd0);
        check("reset_block_out", 256'(blockOut), 256'd0);
        resetN = 1'b1; inValid = 1'b0;
        @(negedge clk);

        // Nk=4 key 00..0f, key_load randomised after byte 0
        for (int i = 0; i < 16; i++)
            sendByte(8'(i), (i == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0);
        check("key4_valid_latency", 256'(keyValid), 256'd1);
        check("key4_value", keyOut, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        check("key4_no_block", 256'(blockValid), 256'd0);

        // Data block with block_ready already high
        blockReady = 1'b1;
        for (int i = 0; i < 16; i++)
            sendByte(8'(i * 8'h11), (i == 0) ? 1'b0 : 1'($urandom_range(0, 1)), 1'b0);
        check("data_valid", 256'(blockValid), 256'd1);
        check("data_value", 256'(blockOut), 256'(128'h00112233445566778899aabbccddeeff));
        check("data_hold_in_ready", 256'(inReady), 256'd0);
        @(negedge clk);
        check("data_valid_one_cycle", 256'(blockValid), 256'd0);
        check("data_in_ready_back", 256'(inReady), 256'd1);
        check("data_keeps_key_valid", 256'(keyValid), 256'd1);

        // Backpressure: five cycles of offered bytes while holding
        blockReady = 1'b0;
        for (int i = 0; i < 16; i++) sendByte(8'($urandom), 1'b0, 1'b0);
        repeat (5) begin
            inValid = 1'b1; inByte = 8'hee; keyLoad = 1'b1;
            #1 check("bp_in_ready", 256'(inReady), 256'd0);
            check("bp_block_valid", 256'(blockValid), 256'd1);
            @(negedge clk);
        end
        inValid = 1'b0; blockReady = 1'b1;
        @(negedge clk);
        check("bp_released", 256'(blockValid), 256'd0);
        for (int i = 0; i < 16; i++) sendByte(8'h30 + 8'(i), 1'b0, 1'b0);
        check("bp_next_block", 256'(blockOut), 256'(128'h303132333435363738393a3b3c3d3e3f));

        // Flush after seven bytes, with a byte offered in the flush cycle
        for (int i = 0; i < 7; i++) sendByte(8'($urandom), 1'b0, 1'b0);
        flush = 1'b1; inValid = 1'b1; inByte = 8'h99;
        @(negedge clk);
        flush = 1'b0; inValid = 1'b0;
        cur.delete();
        check("flush_key_kept", 256'(keyValid), 256'd1);
        for (int i = 0; i < 16; i++) sendByte(8'ha0 + 8'(i), 1'b0, 1'b0);
        check("flush_block", 256'(blockOut), 256'(128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf));

        // Same abort via reset
        for (int i = 0; i < 7; i++) sendByte(8'($urandom), 1'b0, 1'b0);
        resetN = 1'b0; inValid = 1'b1; inByte = 8'h99;
        #1 check("abort_reset_in_ready", 256'(inReady), 256'd0);
        @(negedge clk);
        resetN = 1'b1; inValid = 1'b0;
        cur.delete();
        check("abort_reset_key_cleared", 256'(keyValid), 256'd0);
        for (int i = 0; i < 16; i++) sendByte(8'ha0 + 8'(i), 1'b0, 1'b0);
        check("reset_abort_block", 256'(blockOut), 256'(128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf));

        // Randomised traffic on Nk=4
        randomGroups(12, 2);

        // Switch to the Nk=8 loader
        resetN = 1'b0;
        @(negedge clk);
        sel = 1'b1;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        cur.delete();
        @(negedge clk);

        // 32 key bytes with random gaps
        blockReady = 1'b1;
        for (int i = 0; i < 32; i++) begin
            idle($urandom_range(0, 3));
            sendByte(8'(i), (i == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0);
        end
        check("key8_valid", 256'(keyValid), 256'd1);
        check("key8_value", keyOut,
              256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        sendByte(8'h80, 1'b1, 1'b0);
        check("key8_reload_clears", 256'(keyValid), 256'd0);
        for (int i = 1; i < 32; i++) begin
            idle($urandom_range(0, 2));
            sendByte(8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end
        check("key8_reload_valid", 256'(keyValid), 256'd1);

        randomGroups(10, 3);

        check("key_queue_drained", 256'(keyQ.size()), 256'd0);
        check("block_queue_drained", 256'(blkQ.size()), 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
